// File: rtl/div_sequencer.sv
// Iterative radix-2 restoring divider for SDIV/UDIV with pipeline stall control.
// Optional macro DIV_EARLY_TERM_EN: skip iterations when |dividend| < |divisor|.
module div_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero
);

  localparam logic [2:0] OP_SDIV = 3'b101;
  localparam logic [2:0] OP_UDIV = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_FIX,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic             is_sdiv, div_op, can_accept, accept;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             ge;

  assign is_sdiv    = (ALUControl == OP_SDIV);
  assign div_op     = is_sdiv || (ALUControl == OP_UDIV);
  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign accept     = Start && div_op && can_accept;

  // Magnitudes; |INT_MIN| wraps to 2^(WIDTH-1), which is exact as unsigned.
  assign abs_a = (is_sdiv && SrcA[WIDTH-1]) ? -SrcA : SrcA;
  assign abs_b = (is_sdiv && SrcB[WIDTH-1]) ? -SrcB : SrcB;

  // One restoring step: remainder bits in r_q, dividend shifts out of a_q as quotient shifts in.
  assign rem_sh  = {r_q, a_q[WIDTH-1]};
  assign ge      = (rem_sh >= {1'b0, b_q});
  assign rem_sub = rem_sh[WIDTH-1:0] - b_q;

  assign Stall     = busy_q | accept;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Quotient  = quot_q;
  assign Remainder = rem_q;
  assign DivByZero = dbz_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          a_d    = abs_a;
          b_d    = abs_b;
          r_d    = '0;
          negq_d = is_sdiv && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
          negr_d = is_sdiv && SrcA[WIDTH-1];
          if (SrcB == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            quot_d  = '0;
            rem_d   = SrcA;
            dbz_d   = 1'b1;
          end else begin
            state_d = ST_ITER;
            cnt_d   = CNT_W'(WIDTH - 1);
            busy_d  = 1'b1;
`ifdef DIV_EARLY_TERM_EN
            if (abs_a < abs_b) begin
              state_d = ST_FIX;
              a_d     = '0;
              r_d     = abs_a;
            end
`endif
          end
        end
      end

      ST_ITER: begin
        busy_d = 1'b1;
        a_d    = {a_q[WIDTH-2:0], ge};
        r_d    = ge ? rem_sub : rem_sh[WIDTH-1:0];
        if (cnt_q == '0) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_FIX: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        quot_d  = negq_q ? -a_q : a_q;
        rem_d   = negr_q ? -r_q : r_q;
        dbz_d   = 1'b0;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed cases plus random operands against an arithmetic model.
module tb_div_sequencer;

  localparam int unsigned W = 32;
  localparam logic [2:0] SDIV = 3'b101;
  localparam logic [2:0] UDIV = 3'b110;

  logic         clk = 1'b0;
  logic         reset;
  logic         Start;
  logic [2:0]   ALUControl;
  logic [W-1:0] SrcA, SrcB;
  logic         Busy, Stall, Done, DivByZero;
  logic [W-1:0] Quotient, Remainder;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] prev_q = '0;
  logic [W-1:0] prev_r = '0;

  always #5 clk = ~clk;

  div_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .Start     (Start),
    .ALUControl(ALUControl),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Busy      (Busy),
    .Stall     (Stall),
    .Done      (Done),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .DivByZero (DivByZero)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ARM divide semantics from plain integer arithmetic (64-bit so INT_MIN/-1 simply wraps).
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z, output int lat);
    longint sa, sb, qa, ra;
    if (b == '0) begin
      q = '0; r = a; z = 1'b1; lat = 1;
      return;
    end
    z = 1'b0;
    if (op == SDIV) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    qa = sa / sb;
    ra = sa % sb;
    q = qa[31:0];
    r = ra[31:0];
    lat = W + 2;
`ifdef DIV_EARLY_TERM_EN
    if (((sa < 0) ? -sa : sa) < ((sb < 0) ? -sb : sb)) lat = 2;
`endif
  endfunction

  // Issue one divide; optionally re-pulse Start at cycle 'poke' of the run, which must be ignored.
  task automatic do_div(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int poke);
    logic [W-1:0] eq, er;
    logic ez;
    int elat, lat, stall_bad;
    model(op, a, b, eq, er, ez, elat);
    @(negedge clk);
    Start = 1'b1; ALUControl = op; SrcA = a; SrcB = b;
    #1 chk({tag, ".stall_acc"}, 64'(Stall), 64'(1'b1));
    @(negedge clk);
    Start = 1'b0;
    lat = 1;
    stall_bad = 0;
    while (Done !== 1'b1 && lat < 100) begin
      if (lat == 1) begin
        chk({tag, ".busy1"}, 64'(Busy), 64'(1'b1));
        chk({tag, ".q_held"}, 64'(Quotient), 64'(prev_q));
      end
      if (Stall !== 1'b1) stall_bad++;
      if (poke != 0 && lat == poke) begin
        Start = 1'b1; ALUControl = UDIV; SrcA = $urandom; SrcB = W'($urandom_range(1, 50));
      end else begin
        Start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    Start = 1'b0;
    chk({tag, ".latency"}, 64'(lat), 64'(elat));
    chk({tag, ".stall_run"}, 64'(stall_bad), 64'(0));
    chk({tag, ".quot"}, 64'(Quotient), 64'(eq));
    chk({tag, ".rem"}, 64'(Remainder), 64'(er));
    chk({tag, ".dbz"}, 64'(DivByZero), 64'(ez));
    chk({tag, ".busy_done"}, 64'(Busy), 64'(1'b0));
    #1 chk({tag, ".stall_done"}, 64'(Stall), 64'(1'b0));
    prev_q = eq;
    prev_r = er;
    @(negedge clk);
    chk({tag, ".done_pulse"}, 64'(Done), 64'(1'b0));
    chk({tag, ".q_stable"}, 64'(Quotient), 64'(eq));
  endtask

  initial begin
    int lat, kind, dcount;
    logic [2:0]   op;
    logic [W-1:0] a, b;

    reset = 1'b1; Start = 1'b0; ALUControl = 3'b000; SrcA = '0; SrcB = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst.busy", 64'(Busy), 64'(1'b0));
    chk("rst.done", 64'(Done), 64'(1'b0));
    chk("rst.stall", 64'(Stall), 64'(1'b0));
    chk("rst.quot", 64'(Quotient), 64'(0));
    chk("rst.rem", 64'(Remainder), 64'(0));
    chk("rst.dbz", 64'(DivByZero), 64'(1'b0));

    // Non-divide ALU ops must never start the unit.
    Start = 1'b1; ALUControl = 3'b000; SrcA = 100; SrcB = 7;
    #1 chk("nodiv000.stall", 64'(Stall), 64'(1'b0));
    @(negedge clk);
    chk("nodiv000.busy", 64'(Busy), 64'(1'b0));
    chk("nodiv000.done", 64'(Done), 64'(1'b0));
    ALUControl = 3'b111;
    #1 chk("nodiv111.stall", 64'(Stall), 64'(1'b0));
    @(negedge clk);
    chk("nodiv111.busy", 64'(Busy), 64'(1'b0));
    Start = 1'b0;

    do_div("udiv_100_7", UDIV, 32'd100, 32'd7, 0);
    do_div("sdiv_m100_7", SDIV, 32'hFFFF_FF9C, 32'd7, 0);
    do_div("sdiv_ovf", SDIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_div("udiv_dbz", UDIV, 32'hDEAD_BEEF, 32'd0, 0);
    do_div("udiv_3_10", UDIV, 32'd3, 32'd10, 0);
    do_div("sdiv_m3_10", SDIV, 32'hFFFF_FFFD, 32'd10, 0);
    do_div("sdiv_7_m2", SDIV, 32'd7, 32'hFFFF_FFFE, 0);
    do_div("sdiv_dbz_min", SDIV, 32'h8000_0000, 32'd0, 0);
    do_div("udiv_max_1", UDIV, 32'hFFFF_FFFF, 32'd1, 0);
    do_div("ignore_start", UDIV, 32'd1000, 32'd3, 10);

    // Back-to-back: Start held across the DONE cycle.
    @(negedge clk);
    Start = 1'b1; ALUControl = UDIV; SrcA = 32'd50; SrcB = 32'd5;
    @(negedge clk);
    SrcA = 32'd9; SrcB = 32'd2;
    lat = 1;
    while (Done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b1.latency", 64'(lat), 64'(34));
    chk("b2b1.quot", 64'(Quotient), 64'(10));
    chk("b2b1.rem", 64'(Remainder), 64'(0));
    #1 chk("b2b1.stall_reaccept", 64'(Stall), 64'(1'b1));
    @(negedge clk);
    Start = 1'b0;
    lat = 1;
    while (Done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b2.latency", 64'(lat), 64'(34));
    chk("b2b2.quot", 64'(Quotient), 64'(4));
    chk("b2b2.rem", 64'(Remainder), 64'(1));
    @(negedge clk);
    chk("b2b2.done_pulse", 64'(Done), 64'(1'b0));

    // Reset in the middle of an iteration aborts with no Done.
    Start = 1'b1; ALUControl = UDIV; SrcA = 32'd12345; SrcB = 32'd17;
    @(negedge clk);
    Start = 1'b0;
    repeat (15) @(negedge clk);
    chk("midrst.busy_before", 64'(Busy), 64'(1'b1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst.busy", 64'(Busy), 64'(1'b0));
    chk("midrst.done", 64'(Done), 64'(1'b0));
    chk("midrst.stall", 64'(Stall), 64'(1'b0));
    chk("midrst.quot", 64'(Quotient), 64'(0));
    chk("midrst.rem", 64'(Remainder), 64'(0));
    chk("midrst.dbz", 64'(DivByZero), 64'(1'b0));
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done === 1'b1) dcount++;
    end
    chk("midrst.no_done", 64'(dcount), 64'(0));
    prev_q = '0;
    prev_r = '0;

    // Randomized operand mix.
    for (int i = 0; i < 24; i++) begin
      op   = ($urandom_range(0, 1) == 0) ? SDIV : UDIV;
      a    = $urandom;
      kind = $urandom_range(0, 7);
      case (kind)
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: b = W'(0) - W'($urandom_range(1, 15));
        3: begin a = W'($urandom_range(0, 20)); b = W'($urandom_range(1, 40)); end
        4: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; op = SDIV; end
        default: b = $urandom;
      endcase
      do_div("rnd", op, a, b, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
